// File: rtl/machine_types_pkg.sv
// Shared types for the machine step/issue block: action kind encodings,
// default widths and the default-width slot record.
package machine_types_pkg;

   localparam int NSLOT_DEF  = 4;
   localparam int PTR_W_DEF  = 30;
   localparam int DATA_W_DEF = 63;
   localparam int OUT_W_DEF  = 32;

   typedef enum logic [1:0] {
      KIND_READ  = 2'b00,
      KIND_WRITE = 2'b01,
      KIND_NONE  = 2'b10,
      KIND_RSVD  = 2'b11
   } kind_t;

   typedef struct packed {
      kind_t                 kind;
      logic [PTR_W_DEF-1:0]  ptr;
      logic [DATA_W_DEF-1:0] data;
      logic                  inflight;
   } slot_t;

   // Only reads and writes occupy a slot; none/reserved are swallowed.
   function automatic logic kind_allocates(input logic [1:0] k);
      return (k == KIND_READ) || (k == KIND_WRITE);
   endfunction

endpackage

// File: rtl/machine_slot_select.sv
// Combinational slot picker: grants one occupied, not-in-flight slot.
// MACHINE_RR_ARB_EN selects round-robin from last_idx+1; otherwise lowest index wins.
module machine_slot_select #(
   parameter int NSLOT = 4,
   parameter int IDX_W = 2
) (
   input  logic [NSLOT-1:0] occ,
   input  logic [NSLOT-1:0] inflight,
`ifdef MACHINE_RR_ARB_EN
   input  logic [IDX_W-1:0] last_idx,
`endif
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [NSLOT-1:0] req;

   assign req = occ & ~inflight;

`ifdef MACHINE_RR_ARB_EN
   always_comb begin
      int               k;
      logic [IDX_W-1:0] kidx;
      grant_idx   = '0;
      grant_valid = 1'b0;
      k           = 0;
      kidx        = '0;
      for (int i = 0; i < NSLOT; i++) begin
         k    = (int'(last_idx) + 1 + i) % NSLOT;
         kidx = IDX_W'(k);
         if (!grant_valid && req[kidx]) begin
            grant_valid = 1'b1;
            grant_idx   = kidx;
         end
      end
   end
`else
   always_comb begin
      grant_idx   = '0;
      grant_valid = |req;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (req[i]) grant_idx = IDX_W'(i);
      end
   end
`endif

endmodule

// File: rtl/machine_step_issue.sv
// Slot table plus issue FSM: pending reads/writes are issued one at a time on the
// act_* port; read responses come back as a one-cycle out_valid strobe.
// Build option MACHINE_RR_ARB_EN enables round-robin slot arbitration.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | nothing in flight; grant a pending slot if one exists
//   ST_ISSUE | act_valid high, act_* frozen until act_ready
//   ST_WAIT  | read accepted by memory, waiting for rsp_valid
module machine_step_issue
   import machine_types_pkg::*;
#(
   parameter int NSLOT  = NSLOT_DEF,
   parameter int PTR_W  = PTR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int OUT_W  = OUT_W_DEF
) (
   input  logic              system1000,
   input  logic              system1000_rstn,
   input  logic              enq_valid,
   output logic              enq_ready,
   input  logic [1:0]        enq_kind,
   input  logic [PTR_W-1:0]  enq_ptr,
   input  logic [DATA_W-1:0] enq_data,
   output logic              act_valid,
   input  logic              act_ready,
   output logic [1:0]        act_kind,
   output logic [PTR_W-1:0]  act_ptr,
   output logic [DATA_W-1:0] act_data,
   input  logic              rsp_valid,
   input  logic [DATA_W-1:0] rsp_data,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              step_fail,
   output logic [7:0]        stray_cnt
);

   localparam int IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   typedef struct packed {
      kind_t             kind;
      logic [PTR_W-1:0]  ptr;
      logic [DATA_W-1:0] data;
      logic              inflight;
   } slot_rec_t;

   state_t           state_q, state_d;
   slot_rec_t        slot_q [NSLOT];
   logic [NSLOT-1:0] occ_q;
   logic [NSLOT-1:0] inflight_vec;
   logic [IDX_W-1:0] cur_q;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] free_idx;
   logic             grant_valid;
   logic             load_act, hs_done, take_rsp, free_cur, alloc;

   assign enq_ready = ~&occ_q;
   assign step_fail = (state_q == ST_IDLE) && (occ_q == '0);
   assign alloc     = enq_valid && enq_ready && kind_allocates(enq_kind);

   always_comb begin
      inflight_vec = '0;
      for (int i = 0; i < NSLOT; i++) inflight_vec[i] = slot_q[i].inflight;
   end

   always_comb begin
      free_idx = '0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (!occ_q[i]) free_idx = IDX_W'(i);
      end
   end

`ifdef MACHINE_RR_ARB_EN
   logic [IDX_W-1:0] last_q;

   // Reset to the top index so the first search begins at slot 0.
   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn)  last_q <= IDX_W'(NSLOT - 1);
      else if (load_act)     last_q <= grant_idx;
   end
`endif

   machine_slot_select #(
      .NSLOT (NSLOT),
      .IDX_W (IDX_W)
   ) u_select (
      .occ         (occ_q),
      .inflight    (inflight_vec),
`ifdef MACHINE_RR_ARB_EN
      .last_idx    (last_q),
`endif
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      state_d  = state_q;
      load_act = 1'b0;
      hs_done  = 1'b0;
      take_rsp = 1'b0;
      free_cur = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               load_act = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (act_ready) begin
               hs_done = 1'b1;
               if (act_kind == KIND_WRITE) begin
                  free_cur = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (rsp_valid) begin
               take_rsp = 1'b1;
               free_cur = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         state_q   <= ST_IDLE;
         occ_q     <= '0;
         cur_q     <= '0;
         for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
         act_valid <= 1'b0;
         act_kind  <= KIND_NONE;
         act_ptr   <= '0;
         act_data  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         stray_cnt <= '0;
      end else begin
         state_q   <= state_d;
         out_valid <= take_rsp;

         // Freed slot and allocated slot can never coincide: alloc only targets a free slot.
         if (free_cur) begin
            occ_q[cur_q]           <= 1'b0;
            slot_q[cur_q].inflight <= 1'b0;
         end
         if (alloc) begin
            occ_q[free_idx]           <= 1'b1;
            slot_q[free_idx].kind     <= kind_t'(enq_kind);
            slot_q[free_idx].ptr      <= enq_ptr;
            slot_q[free_idx].data     <= (enq_kind == KIND_WRITE) ? enq_data : '0;
            slot_q[free_idx].inflight <= 1'b0;
         end
         if (load_act) begin
            slot_q[grant_idx].inflight <= 1'b1;
            cur_q     <= grant_idx;
            act_valid <= 1'b1;
            act_kind  <= slot_q[grant_idx].kind;
            act_ptr   <= slot_q[grant_idx].ptr;
            act_data  <= slot_q[grant_idx].data;
         end
         if (hs_done) act_valid <= 1'b0;
         if (take_rsp) out_data <= rsp_data[OUT_W-1:0];
         if (rsp_valid && (state_q != ST_WAIT) && (stray_cnt != 8'hFF))
            stray_cnt <= stray_cnt + 8'd1;
      end
   end

   generate
      if (OUT_W < DATA_W) begin : g_rsp_hi
         logic unused_rsp_hi;
         assign unused_rsp_hi = ^rsp_data[DATA_W-1:OUT_W];
      end
   endgenerate

endmodule

// File: tb/tb_machine_step_issue.sv
// Self-checking bench for machine_step_issue: directed scenarios then random traffic,
// all compared against a slot-table reference model.
module tb_machine_step_issue;

   localparam int NSLOT  = 4;
   localparam int PTR_W  = 30;
   localparam int DATA_W = 63;
   localparam int OUT_W  = 32;

   logic              system1000 = 1'b0;
   logic              system1000_rstn = 1'b0;
   logic              enq_valid, enq_ready;
   logic [1:0]        enq_kind;
   logic [PTR_W-1:0]  enq_ptr;
   logic [DATA_W-1:0] enq_data;
   logic              act_valid, act_ready;
   logic [1:0]        act_kind;
   logic [PTR_W-1:0]  act_ptr;
   logic [DATA_W-1:0] act_data;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic              step_fail;
   logic [7:0]        stray_cnt;

   machine_step_issue #(
      .NSLOT(NSLOT), .PTR_W(PTR_W), .DATA_W(DATA_W), .OUT_W(OUT_W)
   ) dut (
      .system1000      (system1000),
      .system1000_rstn (system1000_rstn),
      .enq_valid       (enq_valid),
      .enq_ready       (enq_ready),
      .enq_kind        (enq_kind),
      .enq_ptr         (enq_ptr),
      .enq_data        (enq_data),
      .act_valid       (act_valid),
      .act_ready       (act_ready),
      .act_kind        (act_kind),
      .act_ptr         (act_ptr),
      .act_data        (act_data),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .step_fail       (step_fail),
      .stray_cnt       (stray_cnt)
   );

   always #5 system1000 = ~system1000;

   int errors = 0;
   int checks = 0;

   // Reference model: slot table plus a single "current action" and its phase.
   bit                m_occ  [NSLOT];
   logic [1:0]        m_kind [NSLOT];
   logic [PTR_W-1:0]  m_ptr  [NSLOT];
   logic [DATA_W-1:0] m_data [NSLOT];
   bit                m_busy, m_act, m_wait, m_out_v;
   int                m_cur, m_last, m_stray;
   logic [OUT_W-1:0]  m_out_d;
   logic [PTR_W-1:0]  issue_log [$];
   logic [PTR_W-1:0]  saved_ptr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int occupied_count();
      int n = 0;
      for (int i = 0; i < NSLOT; i++) if (m_occ[i]) n++;
      return n;
   endfunction

   function automatic int pick();
      int start = 0;
`ifdef MACHINE_RR_ARB_EN
      start = (m_last + 1) % NSLOT;
`endif
      for (int i = 0; i < NSLOT; i++) begin
         int s = (start + i) % NSLOT;
         if (m_occ[s]) return s;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NSLOT; i++) begin
         m_occ[i] = 0; m_kind[i] = 2'b10; m_ptr[i] = '0; m_data[i] = '0;
      end
      m_busy = 0; m_act = 0; m_wait = 0; m_out_v = 0;
      m_cur = 0; m_last = NSLOT - 1; m_stray = 0; m_out_d = '0;
   endtask

   // One clock cycle: check outputs against the model at the falling edge,
   // advance the model with this cycle's inputs, then step past the rising edge.
   task automatic cycle();
      int  fs, p;
      bit  stray_hit, nx_out;
      @(negedge system1000);
      chk("enq_ready", 64'(enq_ready), 64'(occupied_count() < NSLOT));
      chk("step_fail", 64'(step_fail), 64'(occupied_count() == 0));
      chk("act_valid", 64'(act_valid), 64'(m_act));
      if (m_act) begin
         chk("act_kind", 64'(act_kind), 64'(m_kind[m_cur]));
         chk("act_ptr",  64'(act_ptr),  64'(m_ptr[m_cur]));
         chk("act_data", 64'(act_data), 64'(m_data[m_cur]));
      end
      chk("out_valid", 64'(out_valid), 64'(m_out_v));
      chk("out_data",  64'(out_data),  64'(m_out_d));
      chk("stray_cnt", 64'(stray_cnt), 64'(m_stray));
      if (act_valid && act_ready) issue_log.push_back(act_ptr);

      fs = -1;
      if (enq_valid && occupied_count() < NSLOT && (enq_kind == 2'b00 || enq_kind == 2'b01))
         for (int i = NSLOT - 1; i >= 0; i--) if (!m_occ[i]) fs = i;
      stray_hit = rsp_valid && !m_wait;
      nx_out = 0;
      if (!m_busy) begin
         p = pick();
         if (p >= 0) begin m_busy = 1; m_act = 1; m_cur = p; m_last = p; end
      end else if (m_act) begin
         if (act_ready) begin
            m_act = 0;
            if (m_kind[m_cur] == 2'b01) begin m_occ[m_cur] = 0; m_busy = 0; end
            else m_wait = 1;
         end
      end else if (m_wait && rsp_valid) begin
         nx_out = 1;
         m_out_d = rsp_data[OUT_W-1:0];
         m_occ[m_cur] = 0; m_busy = 0; m_wait = 0;
      end
      m_out_v = nx_out;
      if (stray_hit && m_stray < 255) m_stray++;
      if (fs >= 0) begin
         m_occ[fs] = 1; m_kind[fs] = enq_kind; m_ptr[fs] = enq_ptr;
         m_data[fs] = (enq_kind == 2'b01) ? enq_data : '0;
      end
      @(posedge system1000);
      #1;
   endtask

   task automatic enq(input logic [1:0] k, input logic [PTR_W-1:0] p, input logic [DATA_W-1:0] d);
      enq_valid = 1'b1; enq_kind = k; enq_ptr = p; enq_data = d;
      cycle();
      enq_valid = 1'b0; enq_kind = 2'b10;
   endtask

   task automatic check_reset_values();
      chk("rst_act_valid", 64'(act_valid), 64'(0));
      chk("rst_act_kind",  64'(act_kind),  64'(2'b10));
      chk("rst_act_ptr",   64'(act_ptr),   64'(0));
      chk("rst_act_data",  64'(act_data),  64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data",  64'(out_data),  64'(0));
      chk("rst_stray",     64'(stray_cnt), 64'(0));
      chk("rst_step_fail", 64'(step_fail), 64'(1));
      chk("rst_enq_ready", 64'(enq_ready), 64'(1));
   endtask

   initial begin
      enq_valid = 0; enq_kind = 2'b10; enq_ptr = '0; enq_data = '0;
      act_ready = 0; rsp_valid = 0; rsp_data = '0;
      model_reset();

      repeat (3) @(posedge system1000);
      #1;
      check_reset_values();
      system1000_rstn = 1'b1;
      repeat (2) cycle();

      // Single write, memory always ready: act_valid two cycles after enqueue.
      act_ready = 1'b1;
      enq(2'b01, 30'h5, 63'h7);
      cycle();
      chk("wr_act_valid", 64'(act_valid), 64'(1));
      chk("wr_act_kind",  64'(act_kind),  64'(2'b01));
      chk("wr_act_ptr",   64'(act_ptr),   64'(30'h5));
      chk("wr_act_data",  64'(act_data),  64'(63'h7));
      repeat (2) cycle();
      chk("wr_step_fail", 64'(step_fail), 64'(1));

      // Read held off by act_ready for three cycles, then answered.
      act_ready = 1'b0;
      enq(2'b00, 30'h10, 63'h1234);
      cycle();
      saved_ptr = act_ptr;
      chk("rd_act_ptr",  64'(saved_ptr), 64'(30'h10));
      chk("rd_act_data", 64'(act_data),  64'(0));
      repeat (3) cycle();
      chk("rd_hold_valid", 64'(act_valid), 64'(1));
      chk("rd_hold_ptr",   64'(act_ptr),   64'(saved_ptr));
      act_ready = 1'b1;
      cycle();
      act_ready = 1'b0;
      rsp_valid = 1'b1; rsp_data = 63'h1_DEADBEEF;
      cycle();
      rsp_valid = 1'b0; rsp_data = '0;
      chk("rd_out_valid", 64'(out_valid), 64'(1));
      chk("rd_out_data",  64'(out_data),  64'(32'hDEADBEEF));
      cycle();
      chk("rd_out_pulse", 64'(out_valid), 64'(0));
      chk("rd_out_hold",  64'(out_data),  64'(32'hDEADBEEF));

      // Fill all slots, offer a fifth, then complete one.
      issue_log.delete();
      for (int i = 0; i < NSLOT; i++) enq(2'b01, PTR_W'(32'h20 + i), DATA_W'(i + 1));
      chk("full_enq_ready", 64'(enq_ready), 64'(0));
      enq(2'b01, 30'h99, 63'h99);
      act_ready = 1'b1;
      cycle();
      act_ready = 1'b0;
      chk("freed_enq_ready", 64'(enq_ready), 64'(1));
      act_ready = 1'b1;
      repeat (12) cycle();
      chk("full_log_size", 64'(issue_log.size()), 64'(NSLOT));
      for (int i = 0; i < NSLOT; i++)
         chk("full_log_ptr", 64'(issue_log[i]), 64'(32'h20 + i));

      // Stray responses while idle: counter saturates, no result strobe.
      act_ready = 1'b0;
      rsp_valid = 1'b1; rsp_data = 63'h55;
      repeat (300) cycle();
      rsp_valid = 1'b0;
      chk("stray_sat", 64'(stray_cnt), 64'(8'hFF));
      chk("stray_no_out", 64'(out_valid), 64'(0));

      // Issue order with four writes, then a two-entry refill.
      issue_log.delete();
      for (int i = 0; i < NSLOT; i++) enq(2'b01, PTR_W'(i), DATA_W'(32'hA0 + i));
      act_ready = 1'b1;
      repeat (12) cycle();
      chk("order_size", 64'(issue_log.size()), 64'(NSLOT));
      for (int i = 0; i < NSLOT; i++) chk("order_ptr", 64'(issue_log[i]), 64'(i));
      issue_log.delete();
      act_ready = 1'b0;
      enq(2'b01, 30'h40, 63'h1);
      enq(2'b01, 30'h42, 63'h2);
      act_ready = 1'b1;
      repeat (8) cycle();
      chk("refill_size", 64'(issue_log.size()), 64'(2));
      chk("refill_first",  64'(issue_log[0]), 64'(30'h40));
      chk("refill_second", 64'(issue_log[1]), 64'(30'h42));

      // Reset while a read waits for its response: no completion afterwards.
      enq(2'b00, 30'h77, 63'h0);
      repeat (2) cycle();
      system1000_rstn = 1'b0;
      model_reset();
      #2;
      check_reset_values();
      @(posedge system1000);
      #1;
      system1000_rstn = 1'b1;
      act_ready = 1'b0;
      rsp_valid = 1'b1; rsp_data = 63'h3_0000_0001;
      cycle();
      rsp_valid = 1'b0;
      repeat (2) cycle();

      // Random traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         enq_valid = ($urandom_range(0, 99) < 45);
         enq_kind  = 2'($urandom_range(0, 3));
         enq_ptr   = PTR_W'($urandom());
         enq_data  = DATA_W'({$urandom(), $urandom()});
         act_ready = ($urandom_range(0, 99) < 55);
         rsp_valid = ($urandom_range(0, 99) < 35);
         rsp_data  = DATA_W'({$urandom(), $urandom()});
         cycle();
      end
      enq_valid = 1'b0; rsp_valid = 1'b0; act_ready = 1'b1;
      repeat (20) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
